// File: rtl/multi_edge_det.sv
// rtl/multi_edge_det.sv - multi-channel synchronised, glitch-filtered edge detector with sticky flags
module multi_edge_det #(
    parameter int   N_CH        = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter int   CNT_W       = $clog2(FILT_LEN + 1),
    parameter logic RST_LVL     = 1'b1
) (
    input  logic              i_Clk,
    input  logic              i_reset_n,
    input  logic [N_CH-1:0]   i_sig,
    input  logic [2*N_CH-1:0] i_mode,
    input  logic [N_CH-1:0]   i_clear,
    output logic [N_CH-1:0]   o_sig,
    output logic [N_CH-1:0]   o_rise,
    output logic [N_CH-1:0]   o_fall,
    output logic [N_CH-1:0]   o_flag,
    output logic [N_CH-1:0]   o_ovf,
    output logic              o_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [N_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_CH-1:0]                  sig_q, sig_d;
    logic [N_CH-1:0]                  rise_q, rise_d;
    logic [N_CH-1:0]                  fall_q, fall_d;
    logic [N_CH-1:0]                  flag_q, flag_d;
    logic [N_CH-1:0]                  ovf_q, ovf_d;
    logic [N_CH-1:0]                  sync_s;
    logic [N_CH-1:0]                  evt;

    always_comb begin
        sync_d = sync_q;
        cnt_d  = cnt_q;
        sig_d  = sig_q;
        rise_d = '0;
        fall_d = '0;
        flag_d = flag_q;
        ovf_d  = ovf_q;
        sync_s = '0;
        evt    = '0;
        for (int c = 0; c < N_CH; c++) begin
            sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], i_sig[c]};
            sync_s[c] = sync_q[c][SYNC_STAGES-1];

            // A matching sample restarts the count, so glitches shorter than FILT_LEN vanish.
            if (sync_s[c] == sig_q[c]) begin
                cnt_d[c] = '0;
            end else if (cnt_q[c] == CNT_MAX) begin
                cnt_d[c]  = '0;
                sig_d[c]  = sync_s[c];
                rise_d[c] = sync_s[c];
                fall_d[c] = ~sync_s[c];
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end

            evt[c]    = (rise_d[c] & i_mode[2*c]) | (fall_d[c] & i_mode[2*c+1]);
            // A new event beats a simultaneous clear, but that edge is not counted as an overflow.
            flag_d[c] = (flag_q[c] & ~i_clear[c]) | evt[c];
            ovf_d[c]  = (ovf_q[c] & ~i_clear[c]) | (evt[c] & flag_q[c] & ~i_clear[c]);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_reset_n) begin
            sync_q <= {(N_CH*SYNC_STAGES){RST_LVL}};
            cnt_q  <= '0;
            sig_q  <= {N_CH{RST_LVL}};
            rise_q <= '0;
            fall_q <= '0;
            flag_q <= '0;
            ovf_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            sig_q  <= sig_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_sig  = sig_q;
    assign o_rise = rise_q;
    assign o_fall = fall_q;
    assign o_flag = flag_q;
    assign o_ovf  = ovf_q;
    assign o_irq  = |flag_q;

endmodule
